result_writer: RTL and testbench
================================

Name: result_writer

Overview:
Output-side counterpart of the DCNN IO input loader. It accepts a fixed-length stream of 16-bit result words from the compute core over a valid/ready handshake and buffers them in a small FIFO. It then writes them to consecutive addresses of an external result memory through a write/ack interface, starting at a programmable base address. It reports busy and done, so the controller knows when the result dump is complete.

Parameters:
DATA_W, 16, width of a result word and of mem_wdata
ADDR_W, 16, width of memory address and word count
FIFO_DEPTH, 8, buffer entries (power of two, >=2)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  single-cycle request to begin a transfer; sampled only in IDLE
base_addr  input  ADDR_W  first write address; latched on accepted start
num_words  input  ADDR_W  number of words to transfer; latched on accepted start
in_valid  input  1  producer has a word on in_data
in_data  input  DATA_W  result word
in_ready  output  1  block accepts in_data this cycle
mem_we  output  1  write request
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
mem_ack  input  1  memory accepts the current write this cycle
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the last word is acknowledged

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, FIFO emptied, counters=0, addr=0. Outputs in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. Reset mid-transfer aborts the transfer: no done pulse, and buffered words are discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches base_addr into addr_reg and num_words into total_reg, and clears acc_cnt and wr_cnt.
  - If num_words=0, go to DONE.
  - Otherwise go to RUN. busy=1 from the next cycle.
- start outside IDLE is ignored.
- RUN, input side:
  - in_ready = !fifo_full && (acc_cnt < total_reg). Derived from registered state only; it does not depend on in_valid.
  - A push occurs when in_valid && in_ready. acc_cnt then increments.
  - Words offered after total_reg words have been accepted see in_ready=0.
- RUN, output side:
  - mem_we = !fifo_empty. mem_wdata = FIFO head. mem_addr = addr_reg.
  - mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_we && mem_ack: pop the FIFO, addr_reg = addr_reg+1 (wraps modulo 2^ADDR_W), wr_cnt increments.
  - mem_ack while mem_we=0 is ignored.
- Latency: a word pushed at edge t is visible on mem_we/mem_wdata in the cycle after t at the earliest. With mem_ack tied high, throughput is one word per cycle.
- Simultaneous push and pop: both happen. Occupancy is unchanged.
- Full FIFO: in_ready=0 even if a pop occurs in the same cycle; there is no combinational bypass.
- RUN to DONE: on the edge where the ack of word total_reg is taken (wr_cnt reaches total_reg).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. In IDLE: busy=0, in_ready=0, mem_we=0.
- mem_addr in IDLE/DONE holds its last value. After reset it is 0.

Decomposition:
- Shared package io_pkg:
  - DATA_W and ADDR_W defaults.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module sync_fifo, parameterised by width and depth, on the same clk/rst_n:
  - Ports: push, pop, din, dout (head, first-word-fall-through), full, empty.
  - Not reusable as a rename of the loader.
- result_writer holds the FSM, the counters and the address generator.

Test Plan:
- Reset, then idle: check every output is 0. Pulse rst_n=0 mid-RUN after 3 of 5 words: outputs return to 0 next cycle, no done pulse, and a fresh start works.
- base_addr=16'h0100, num_words=4, in_valid=1 with data A1..A4, mem_ack=1: writes A1..A4 to 0x0100..0x0103 on consecutive cycles, then done=1 for one cycle and busy=0 afterwards.
- mem_ack=0 held for 12 cycles while 10 words are offered: in_ready drops after 8 accepts and mem_we/addr/data stay stable. Release ack: all 10 words are written in order and done pulses once.
- num_words=0 start: DONE next cycle, done pulses once, mem_we never asserted. A second start while busy is ignored.
- base_addr=16'hFFFE, num_words=4: addresses FFFE, FFFF, 0000, 0001. An extra fifth in_valid word sees in_ready=0 and is never written.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the DCNN IO blocks: default widths and the
// transfer FSM encoding used by the loader and the result writer.
package io_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
// Pushes while full and pops while empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: non-blocking assignments in every clocked block, so all registers
  // update together and read order inside the block never matters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // count, so stale entries are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/result_writer.sv
// Drains a fixed-length stream of result words from the compute core through
// a FIFO into consecutive addresses of the external result memory.
module result_writer
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] total_reg;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;

  logic              running;
  logic              push;
  logic              pop;
  logic              last_ack;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign running = (state == ST_RUN);

  // Input side looks only at registered state, so a pop in the same cycle
  // never frees a slot for a push (no combinational path from mem_ack).
  assign in_ready = running && !fifo_full && (acc_cnt < total_reg);
  assign push     = in_valid && in_ready;

  assign mem_we   = running && !fifo_empty;
  assign pop      = mem_we && mem_ack;
  assign last_ack = pop && ((wr_cnt + 1'b1) == total_reg);

  assign mem_addr  = addr_reg;
  // Head is masked while nothing is pending so the bus reads zero after reset.
  assign mem_wdata = mem_we ? fifo_head : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_reg  <= '0;
      total_reg <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_reg  <= base_addr;
            total_reg <= num_words;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            state     <= (num_words == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (push) acc_cnt <= acc_cnt + 1'b1;
          if (pop) begin
            addr_reg <= addr_reg + 1'b1;
            wr_cnt   <= wr_cnt + 1'b1;
          end
          if (last_ack) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: a transaction-level model checked
// every cycle, plus directed scenarios with literal expected write logs.
module tb_result_writer;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic              done;

  result_writer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  bit          m_armed = 1'b0;
  int          m_total = 0;
  int          m_acc = 0;
  int          m_wr = 0;
  logic [15:0] m_base = '0;
  logic [15:0] m_words[$];

  function automatic bit exp_ready();
    return (m_phase == M_RUN) && ((m_acc - m_wr) < FIFO_DEPTH) && (m_acc < m_total);
  endfunction

  function automatic bit exp_we();
    return (m_phase == M_RUN) && (m_acc > m_wr);
  endfunction

  function automatic logic [15:0] exp_wdata();
    return exp_we() ? m_words[m_wr] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    bit acc_now;
    bit wr_now;
    if (!rst_n) begin
      m_phase = M_IDLE;
      m_total = 0;
      m_acc   = 0;
      m_wr    = 0;
      m_base  = '0;
      m_words.delete();
      m_armed = 1'b1;
    end else if (m_armed) begin
      case (m_phase)
        M_IDLE: if (start) begin
          m_base  = base_addr;
          m_total = int'(num_words);
          m_acc   = 0;
          m_wr    = 0;
          m_words.delete();
          m_phase = (num_words == 0) ? M_DONE : M_RUN;
        end
        M_RUN: begin
          acc_now = in_valid && exp_ready();
          wr_now  = mem_ack && exp_we();
          if (acc_now) begin
            m_words.push_back(in_data);
            m_acc++;
          end
          if (wr_now) m_wr++;
          if (m_wr == m_total) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("cmp_in_ready", in_ready, exp_ready());
      check("cmp_mem_we", mem_we, exp_we());
      check("cmp_mem_addr", mem_addr, 16'(m_base + 16'(m_wr)));
      check("cmp_mem_wdata", mem_wdata, exp_wdata());
      check("cmp_busy", busy, m_phase != M_IDLE);
      check("cmp_done", done, m_phase == M_DONE);
    end
  end

  // ---------------- observed-write log for literal checks ----------------
  int          cyc = 0;
  int          done_cnt = 0;
  int          acc_seen = 0;
  int          we_seen = 0;
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n && mem_we && mem_ack) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
    if (rst_n && done)             done_cnt++;
    if (rst_n && in_valid && in_ready) acc_seen++;
    if (rst_n && mem_we)           we_seen++;
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] tx[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_cnt = 0;
    acc_seen = 0;
    we_seen  = 0;
  endtask

  task automatic start_xfer(input logic [15:0] base, input logic [15:0] n);
    start     = 1'b1;
    base_addr = base;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic produce(input int n, input int budget, output int accepted);
    int waited;
    bit got;
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = tx[i];
      got      = 1'b0;
      waited   = 0;
      while (!got && waited < budget) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!got) break;
      accepted++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int w = 0;
    while (done_cnt == 0 && w < budget) begin
      tick();
      w++;
    end
    check(name, done_cnt != 0, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int acc;

    // Reset, then idle.
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_outputs_zero("idle");

    // Basic transfer with ack tied high; a second start during RUN is ignored.
    for (int i = 0; i < 16; i++) tx[i] = 16'(16'h00A1 + i);
    clear_log();
    mem_ack = 1'b1;
    start_xfer(16'h0100, 16'd4);
    fork
      produce(4, 20, acc);
      begin
        tick();
        start_xfer(16'h0555, 16'd7);
      end
    join
    wait_done("basic_done_timeout", 20);
    tick();
    check("basic_accepts", acc, 4);
    check("basic_nwrites", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("basic_addr", log_addr[i], 16'h0100 + 16'(i));
      check("basic_data", log_data[i], 16'h00A1 + 16'(i));
      check("basic_consecutive", log_cyc[i], log_cyc[0] + i);
    end
    check("basic_done_once", done_cnt, 1);
    check("basic_busy_after", busy, 0);

    // Back-pressure: ack low for 12 cycles while 10 words are offered.
    for (int i = 0; i < 16; i++) tx[i] = 16'(16'hB000 + 16'h0111 * i);
    clear_log();
    mem_ack = 1'b0;
    start_xfer(16'h0300, 16'd10);
    fork
      produce(10, 40, acc);
      begin
        repeat (12) tick();
        check("bp_accepts_held", acc_seen, 8);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_hold_we", mem_we, 1);
        check("bp_hold_addr", mem_addr, 16'h0300);
        check("bp_hold_data", mem_wdata, 16'hB000);
        mem_ack = 1'b1;
      end
    join
    wait_done("bp_done_timeout", 40);
    repeat (2) tick();
    check("bp_accepts", acc, 10);
    check("bp_nwrites", log_addr.size(), 10);
    for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
      check("bp_addr", log_addr[i], 16'h0300 + 16'(i));
      check("bp_data", log_data[i], 16'(16'hB000 + 16'h0111 * i));
    end
    check("bp_done_once", done_cnt, 1);

    // Zero-length transfer; start during DONE is ignored.
    clear_log();
    start_xfer(16'h0040, 16'd0);
    check("zero_done_next", done, 1);
    check("zero_busy", busy, 1);
    start     = 1'b1;
    base_addr = 16'h0777;
    num_words = 16'd3;
    tick();
    start = 1'b0;
    check("zero_ignored_busy", busy, 0);
    repeat (4) tick();
    check("zero_done_once", done_cnt, 1);
    check("zero_no_we", we_seen, 0);
    check("zero_addr_hold", mem_addr, 16'h0040);

    // Address wrap; a fifth offered word is refused.
    for (int i = 0; i < 16; i++) tx[i] = 16'(16'hC0DE + i);
    clear_log();
    start_xfer(16'hFFFE, 16'd4);
    produce(5, 10, acc);
    wait_done("wrap_done_timeout", 10);
    repeat (2) tick();
    check("wrap_accepts", acc, 4);
    check("wrap_nwrites", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("wrap_addr0", log_addr[0], 16'hFFFE);
      check("wrap_addr1", log_addr[1], 16'hFFFF);
      check("wrap_addr2", log_addr[2], 16'h0000);
      check("wrap_addr3", log_addr[3], 16'h0001);
      check("wrap_data3", log_data[3], 16'hC0E1);
    end
    check("wrap_done_once", done_cnt, 1);

    // Reset in the middle of a transfer, then a fresh start.
    for (int i = 0; i < 16; i++) tx[i] = 16'(16'hD100 + i);
    clear_log();
    mem_ack = 1'b0;
    start_xfer(16'h0200, 16'd5);
    produce(3, 10, acc);
    check("abort_accepts", acc, 3);
    rst_n = 1'b0;
    tick();
    check_outputs_zero("abort");
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_writes", log_addr.size(), 0);
    mem_ack = 1'b1;
    start_xfer(16'h0010, 16'd2);
    produce(2, 10, acc);
    wait_done("fresh_done_timeout", 10);
    repeat (2) tick();
    check("fresh_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("fresh_addr0", log_addr[0], 16'h0010);
      check("fresh_data0", log_data[0], 16'hD100);
      check("fresh_addr1", log_addr[1], 16'h0011);
      check("fresh_data1", log_data[1], 16'hD101);
    end
    check("fresh_done_once", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
